lsu_seq: RTL and testbench
==========================

Name: lsu_seq

Overview:
- Load/store sequencer. Initiator side of the data-memory interface.
- Accepts one CPU load/store request at a time, with byte, half or word width.
- Drives a word-wide synchronous RAM that has no byte enables: sub-word stores are performed as read-modify-write.
- Returns sign- or zero-extended load data through a one-cycle response pulse. Sits between the MEM-stage control and the word RAM.

Parameters:
- ADDR_W, 12, word-address width driven to the RAM (covers byte address bits [ADDR_W+1:2]).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_width  in  2  00=byte, 01=half, 10=word; 11 treated as word
- req_extend  in  1  0=sign-extend, 1=zero-extend (loads only)
- req_wd  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rd  out  32  extended load data; 0 for stores
- rsp_misalign  out  1  valid with rsp_valid; see Optional Feature
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2] (registered)
- mem_re  out  1  read strobe
- mem_we  out  1  write strobe
- mem_wd  out  32  write word
- mem_rd  in  32  read word, valid the cycle after mem_re (registered RAM read)

Behaviour:
- Reset values: state=IDLE; req_ready=1; rsp_valid=0; rsp_rd=0; rsp_misalign=0; mem_re=0; mem_we=0; mem_addr=0; mem_wd=0.
- Acceptance: a request is accepted on an edge where req_valid && req_ready. All req_* fields are latched on that edge; later changes to req_* are ignored.
- States: IDLE, RD, WAIT, WR, RESP.
  - IDLE: req_ready=1. On accept: load → RD; word store → WR; byte/half store → RD.
  - RD: mem_re=1, mem_addr=latched word address. Always → WAIT.
  - WAIT: mem_rd is valid in this cycle.
    - Load: select lane, extend, register into rsp_rd, → RESP.
    - Sub-word store: register the merged word into the write buffer, → WR.
  - WR: mem_we=1, mem_wd=write buffer (or req_wd for a word store). → RESP.
  - RESP: rsp_valid=1 for exactly one cycle, → IDLE. No response backpressure.
- Lane select for a byte access: lane = addr[1:0].
  - Load: bits [8·lane+7 : 8·lane].
  - Store merge: replace only that byte of mem_rd with wd[7:0].
- Lane select for a half access: lane = addr[1].
  - Load: bits [16·lane+15 : 16·lane].
  - Store merge: replace only that half of mem_rd with wd[15:0].
- Word access: full 32 bits, no extension.
- Extension: sign copies the lane MSB into the upper bits; zero fills the upper bits with 0.
- Latency from the accept edge to the rsp_valid cycle:
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- req_ready=0 in every state except IDLE. Back-to-back requests need no dead cycle beyond RESP → IDLE.
- mem_re and mem_we are never high in the same cycle. Each strobe is high for exactly one cycle per access.
- Reset during an operation:
  - next state is IDLE and all outputs take their reset values;
  - no rsp_valid is produced for the aborted request;
  - a write not yet strobed is dropped; a completed WR is not undone.
- rsp_rd is cleared to 0 on every store completion.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
  - On accept it goes IDLE → RESP directly, with no mem_re/mem_we.
  - rsp_misalign=1 and rsp_rd=0 in the RESP cycle.
- Undefined:
  - rsp_misalign is tied 0.
  - Word access ignores addr[1:0]; half access ignores addr[0] (aligned down), and is executed normally.

Test Plan:
- RAM word 0x10>>2 = 0x8899AABB; load byte addr 0x12, sign → rsp_rd=0xFFFFFF99 three cycles after accept; mem_re pulsed once, mem_we never.
- Same word, load half addr 0x12, zero → rsp_rd=0x00008899; load word addr 0x10 → 0x8899AABB.
- Store byte 0x5C at addr 0x11 → one mem_re, then mem_we with mem_wd=0x88995CBB; rsp_valid 4 cycles after accept; req_ready low throughout.
- Store word 0xDEADBEEF at addr 0x20 → mem_we in the cycle after accept, mem_addr=0x008, no mem_re, rsp_valid 2 cycles after accept, rsp_rd=0.
- Assert rst during WAIT of a half store → no mem_we, no rsp_valid; next cycle req_ready=1; RAM word unchanged.
- With LSU_MISALIGN_TRAP_EN: load word at addr 0x13 → rsp_valid 1 cycle after accept with rsp_misalign=1, no memory strobes. Without the macro: returns the word at 0x10.

Source files
------------

// File: rtl/lsu_seq_if.sv
// Request/response and word-RAM bus of the load/store sequencer.
// The master modport is the sequencer itself; slave is the CPU/RAM side.
interface lsu_seq_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [1:0]        req_width;
  logic              req_extend;
  logic [31:0]       req_wd;
  logic              rsp_valid;
  logic [31:0]       rsp_rd;
  logic              rsp_misalign;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  modport master (
    input  req_valid, req_we, req_addr, req_width, req_extend, req_wd, mem_rd,
    output req_ready, rsp_valid, rsp_rd, rsp_misalign,
           mem_addr, mem_re, mem_we, mem_wd
  );

  modport slave (
    output req_valid, req_we, req_addr, req_width, req_extend, req_wd, mem_rd,
    input  req_ready, rsp_valid, rsp_rd, rsp_misalign,
           mem_addr, mem_re, mem_we, mem_wd
  );
endinterface

// File: rtl/lsu_seq.sv
// Load/store sequencer driving a word RAM without byte enables (sub-word stores are read-modify-write).
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module lsu_seq #(
  parameter int ADDR_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  lsu_seq_if.master  bus
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t            state;
  logic              we_q;
  logic              ext_q;
  logic [1:0]        width_q;
  logic [1:0]        lane_q;
  logic [15:0]       wd_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              misalign_q;
  logic [31:0]       rsp_rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic              re_q;
  logic              wstrobe_q;
  logic [31:0]       mem_wd_q;
  logic              misaligned;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((bus.req_width == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_width[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  function automatic logic [31:0] load_sel(input logic [31:0] w, input logic [1:0] width,
                                           input logic [1:0] lane, input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = 16'(w >> {lane[1], 4'b0000});
    case (width)
      2'b00:   load_sel = zext ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_sel = zext ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_sel = w;
    endcase
  endfunction

  // Only byte or half widths reach the merge; word stores bypass the read.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] width,
                                        input logic [1:0] lane, input logic [15:0] d);
    logic [31:0] mask;
    logic [31:0] data;
    if (width == 2'b00) begin
      mask = 32'h0000_00FF << {lane, 3'b000};
      data = {24'h0, d[7:0]} << {lane, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {lane[1], 4'b0000};
      data = {16'h0, d} << {lane[1], 4'b0000};
    end
    merge = (w & ~mask) | (data & mask);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= 32'h0;
      misalign_q  <= 1'b0;
      re_q        <= 1'b0;
      wstrobe_q   <= 1'b0;
      addr_q      <= '0;
      mem_wd_q    <= 32'h0;
      we_q        <= 1'b0;
      ext_q       <= 1'b0;
      width_q     <= 2'b00;
      lane_q      <= 2'b00;
      wd_q        <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            ready_q <= 1'b0;
            we_q    <= bus.req_we;
            ext_q   <= bus.req_extend;
            width_q <= bus.req_width;
            lane_q  <= bus.req_addr[1:0];
            wd_q    <= bus.req_wd[15:0];
            addr_q  <= bus.req_addr[ADDR_W+1:2];
            if (misaligned) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              misalign_q  <= 1'b1;
              rsp_rd_q    <= 32'h0;
            end else if (bus.req_we && bus.req_width[1]) begin
              state     <= WR;
              wstrobe_q <= 1'b1;
              mem_wd_q  <= bus.req_wd;
            end else begin
              state <= RD;
              re_q  <= 1'b1;
            end
          end
        end
        RD: begin
          re_q  <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (we_q) begin
            mem_wd_q  <= merge(bus.mem_rd, width_q, lane_q, wd_q);
            wstrobe_q <= 1'b1;
            state     <= WR;
          end else begin
            rsp_rd_q    <= load_sel(bus.mem_rd, width_q, lane_q, ext_q);
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        WR: begin
          wstrobe_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rd_q    <= 32'h0;
          state       <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          misalign_q  <= 1'b0;
          ready_q     <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rd       = rsp_rd_q;
  assign bus.rsp_misalign = misalign_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_re       = re_q;
  assign bus.mem_we       = wstrobe_q;
  assign bus.mem_wd       = mem_wd_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: word RAM model, strobe monitor, latency and data checks.
module tb_lsu_seq;

  logic clk;
  logic rst;

  lsu_seq_if #(.ADDR_W(12)) bus ();

  lsu_seq #(.ADDR_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:4095];
  logic        preload;
  logic [11:0] preload_addr;
  logic [31:0] preload_data;

  int          re_count;
  int          we_count;
  int          rsp_count;
  int          overlap_count;
  logic [31:0] last_wd;
  logic [11:0] last_waddr;

  int errors;
  int checks;

  // Registered-read word RAM: data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (preload) ram[preload_addr] <= preload_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wd;
    if (bus.mem_re) bus.mem_rd <= ram[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (bus.mem_re) re_count <= re_count + 1;
    if (bus.mem_we) begin
      we_count   <= we_count + 1;
      last_wd    <= bus.mem_wd;
      last_waddr <= bus.mem_addr;
    end
    if (bus.mem_re && bus.mem_we) overlap_count <= overlap_count + 1;
    if (bus.rsp_valid) rsp_count <= rsp_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload_word(input logic [11:0] a, input logic [31:0] d);
    preload      = 1'b1;
    preload_addr = a;
    preload_data = d;
    tick();
    preload      = 1'b0;
  endtask

  // Presents one request for the accept edge, then scrambles the fields to prove they were latched.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [1:0] width,
                                input logic ext, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_width  = width;
    bus.req_extend = ext;
    bus.req_wd     = wd;
    tick();
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_addr   = ~addr;
    bus.req_width  = ~width;
    bus.req_extend = ~ext;
    bus.req_wd     = ~wd;
  endtask

  task automatic run_op(input string name, input logic we, input logic [31:0] addr,
                        input logic [1:0] width, input logic ext, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_mis,
                        input int exp_re, input int exp_we);
    int   re0;
    int   we0;
    int   lat;
    logic ready_hi;
    re0      = re_count;
    we0      = we_count;
    apply_stimulus(we, addr, width, ext, wd);
    lat      = 1;
    ready_hi = 1'b0;
    while (bus.rsp_valid !== 1'b1 && lat < 8) begin
      if (bus.req_ready) ready_hi = 1'b1;
      tick();
      lat++;
    end
    if (bus.req_ready) ready_hi = 1'b1;
    check_output({name, "/latency"}, 32'(lat), 32'(exp_lat));
    check_output({name, "/rsp_rd"}, bus.rsp_rd, exp_rd);
    check_output({name, "/misalign"}, {31'h0, bus.rsp_misalign}, {31'h0, exp_mis});
    check_output({name, "/ready_low"}, {31'h0, ready_hi}, 32'h0);
    tick();
    check_output({name, "/pulse_end"}, {31'h0, bus.rsp_valid}, 32'h0);
    check_output({name, "/ready_back"}, {31'h0, bus.req_ready}, 32'h1);
    check_output({name, "/re_count"}, 32'(re_count - re0), 32'(exp_re));
    check_output({name, "/we_count"}, 32'(we_count - we0), 32'(exp_we));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int we0;
    int re0;
    int rsp0;
    errors         = 0;
    checks         = 0;
    re_count       = 0;
    we_count       = 0;
    rsp_count      = 0;
    overlap_count  = 0;
    last_wd        = 32'h0;
    last_waddr     = 12'h0;
    bus.mem_rd     = 32'h0;
    preload        = 1'b0;
    preload_addr   = 12'h0;
    preload_data   = 32'h0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_width  = 2'b00;
    bus.req_extend = 1'b0;
    bus.req_wd     = 32'h0;

    preload_word(12'h004, 32'h8899_AABB);
    preload_word(12'h008, 32'h0000_0000);

    check_output("reset/req_ready", {31'h0, bus.req_ready}, 32'h1);
    check_output("reset/rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_output("reset/rsp_rd", bus.rsp_rd, 32'h0);
    check_output("reset/rsp_misalign", {31'h0, bus.rsp_misalign}, 32'h0);
    check_output("reset/mem_re", {31'h0, bus.mem_re}, 32'h0);
    check_output("reset/mem_we", {31'h0, bus.mem_we}, 32'h0);
    check_output("reset/mem_addr", 32'(bus.mem_addr), 32'h0);
    check_output("reset/mem_wd", bus.mem_wd, 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] loads from word 0x8899AABB");
    run_op("ld_b12_s", 1'b0, 32'h12, 2'b00, 1'b0, 32'h0, 3, 32'hFFFF_FF99, 1'b0, 1, 0);
    run_op("ld_h12_z", 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 3, 32'h0000_8899, 1'b0, 1, 0);
    run_op("ld_w10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 3, 32'h8899_AABB, 1'b0, 1, 0);
    run_op("ld_b10_z", 1'b0, 32'h10, 2'b00, 1'b1, 32'h0, 3, 32'h0000_00BB, 1'b0, 1, 0);
    run_op("ld_h10_s", 1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 3, 32'hFFFF_AABB, 1'b0, 1, 0);
    run_op("ld_b13_s", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 3, 32'hFFFF_FF88, 1'b0, 1, 0);

    $display("[TB] sub-word and word stores");
    run_op("st_b11", 1'b1, 32'h11, 2'b00, 1'b0, 32'hFFFF_FF5C, 4, 32'h0, 1'b0, 1, 1);
    check_output("st_b11/mem_wd", last_wd, 32'h8899_5CBB);
    check_output("st_b11/mem_addr", 32'(last_waddr), 32'h4);
    run_op("ld_w10_after_b", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 3, 32'h8899_5CBB, 1'b0, 1, 0);
    run_op("st_w20", 1'b1, 32'h20, 2'b10, 1'b0, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0, 1);
    check_output("st_w20/mem_wd", last_wd, 32'hDEAD_BEEF);
    check_output("st_w20/mem_addr", 32'(last_waddr), 32'h8);
    run_op("ld_w20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1, 0);
    run_op("ld_w20_width3", 1'b0, 32'h20, 2'b11, 1'b1, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1, 0);
    run_op("st_h12", 1'b1, 32'h12, 2'b01, 1'b0, 32'hFFFF_1234, 4, 32'h0, 1'b0, 1, 1);
    check_output("st_h12/mem_wd", last_wd, 32'h1234_5CBB);

    $display("[TB] reset during WAIT of a half store");
    we0  = we_count;
    re0  = re_count;
    rsp0 = rsp_count;
    apply_stimulus(1'b1, 32'h10, 2'b01, 1'b0, 32'h0000_7777);
    tick();
    check_output("abort/wait_no_we", {31'h0, bus.mem_we}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("abort/req_ready", {31'h0, bus.req_ready}, 32'h1);
    check_output("abort/rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check_output("abort/mem_addr", 32'(bus.mem_addr), 32'h0);
    tick();
    tick();
    check_output("abort/we_count", 32'(we_count - we0), 32'h0);
    check_output("abort/re_count", 32'(re_count - re0), 32'h1);
    check_output("abort/rsp_count", 32'(rsp_count - rsp0), 32'h0);
    run_op("ld_w10_after_abort", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 3, 32'h1234_5CBB, 1'b0, 1, 0);

    $display("[TB] misaligned accesses");
`ifdef LSU_MISALIGN_TRAP_EN
    run_op("mis_w13", 1'b0, 32'h13, 2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_op("mis_h11", 1'b0, 32'h11, 2'b01, 1'b1, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_op("mis_st_w12", 1'b1, 32'h12, 2'b10, 1'b0, 32'hCAFE_F00D, 1, 32'h0, 1'b1, 0, 0);
    run_op("mis_check_ram", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 3, 32'h1234_5CBB, 1'b0, 1, 0);
`else
    run_op("mis_w13", 1'b0, 32'h13, 2'b10, 1'b0, 32'h0, 3, 32'h1234_5CBB, 1'b0, 1, 0);
    run_op("mis_h11", 1'b0, 32'h11, 2'b01, 1'b1, 32'h0, 3, 32'h0000_5CBB, 1'b0, 1, 0);
`endif

    check_output("strobe_overlap", 32'(overlap_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
